// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply (radix-2 Booth) and divide (restoring on magnitudes
// with sign fix-up) producing Hi/Lo, with a one-cycle done pulse and a zero-divisor flag.
module mult_div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic              mult_start,
   input  logic              div_start,
   output logic [DATA_W-1:0] Hi,
   output logic [DATA_W-1:0] Lo,
   output logic              busy,
   output logic              done,
   output logic              div_zero
);
   localparam int W  = DATA_W;
   localparam int CW = $clog2(DATA_W);
   typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;
   state_t state, next;
   logic [CW-1:0] cnt;
   logic last, win, go_mult, go_div, dz, sa, sb;
   // Booth accumulator {P_hi, P_lo, q-1}; P_hi carries two guard bits so +/-2^(W-1) never overflows
   logic [2*W+2:0] acc, acc_next;
   logic [W+1:0] m, ph_add;
   logic [W-1:0] r, q, d, r_next, q_next;
   logic [W:0] shifted, trial;
   assign last    = cnt == CW'(W-1);
   assign win     = state == IDLE || state == DONE;
   assign go_mult = win && mult_start;
   assign go_div  = win && !mult_start && div_start;
   assign busy     = state != IDLE;
   assign done     = state == DONE;
   assign div_zero = done && dz;
   assign ph_add   = acc[1] == acc[0] ? acc[2*W+2:W+1] :
                     acc[0] ? acc[2*W+2:W+1] + m : acc[2*W+2:W+1] - m;
   assign acc_next = {ph_add[W+1], ph_add, acc[W:1]};
   assign shifted  = {r, q[W-1]};
   assign trial    = shifted - {1'b0, d};
   assign r_next   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
   assign q_next   = {q[W-2:0], !trial[W]};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE, DONE: next = go_mult ? MULT : go_div ? (B == '0 ? DONE : DIV) : IDLE;
         MULT:       next = last ? DONE : MULT;
         DIV:        next = last ? FIX : DIV;
         FIX:        next = DONE;
         default:    next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         Hi  <= '0;
         Lo  <= '0;
         acc <= '0;
         m   <= '0;
         r   <= '0;
         q   <= '0;
         d   <= '0;
         sa  <= 1'b0;
         sb  <= 1'b0;
         dz  <= 1'b0;
         cnt <= '0;
      end else if (go_mult) begin
         acc <= {{(W+2){1'b0}}, B, 1'b0};
         m   <= {{2{A[W-1]}}, A};
         cnt <= '0;
         dz  <= 1'b0;
      end else if (go_div) begin
         r   <= '0;
         q   <= A[W-1] ? -A : A;
         d   <= B[W-1] ? -B : B;
         sa  <= A[W-1];
         sb  <= B[W-1];
         cnt <= '0;
         dz  <= B == '0;
      end else begin
         case (state)
            MULT: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (last) begin
                  Hi <= acc_next[2*W:W+1];
                  Lo <= acc_next[W:1];
               end
            end
            DIV: begin
               r   <= r_next;
               q   <= q_next;
               cnt <= cnt + 1'b1;
            end
            // remainder follows the dividend's sign, quotient negative when signs differ
            FIX: begin
               Hi <= sa ? -r : r;
               Lo <= (sa ^ sb) ? -q : q;
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit; expected Hi/Lo/div_zero/latency
// come from plain 64-bit signed arithmetic and are checked by a separate done monitor.
module tb_mult_div_unit;
   localparam int W = 32;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [W-1:0] A = '0, B = '0;
   logic mult_start = 1'b0, div_start = 1'b0;
   logic [W-1:0] Hi, Lo;
   logic busy, done, div_zero;
   int checks = 0, failures = 0, cyc = 0;
   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           start;
      int           lat;
      string        name;
   } exp_t;
   exp_t sbq[$];
   logic [W-1:0] mdl_hi = '0, mdl_lo = '0;

   mult_div_unit #(.DATA_W(W)) dut (
      .clk(clk), .reset_n(reset_n), .A(A), .B(B),
      .mult_start(mult_start), .div_start(div_start),
      .Hi(Hi), .Lo(Lo), .busy(busy), .done(done), .div_zero(div_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         if (done) begin
            if (sbq.size() == 0) chk("spurious_done", 64'd1, 64'd0);
            else begin
               e = sbq.pop_front();
               chk({e.name, "_hi"}, 64'(Hi), 64'(e.hi));
               chk({e.name, "_lo"}, 64'(Lo), 64'(e.lo));
               chk({e.name, "_dz"}, 64'(div_zero), 64'(e.dz));
               chk({e.name, "_lat"}, 64'(cyc - e.start + 1), 64'(e.lat));
               chk({e.name, "_busy"}, 64'(busy), 64'd1);
            end
         end else if (div_zero) chk("dz_without_done", 64'(div_zero), 64'd0);
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ms, input logic ds, input string n);
      exp_t e;
      logic signed [63:0] p, sa64, sb64, qq, rr;
      int t;
      @(negedge clk);
      t = 0;
      while (busy && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (busy) chk("idle_timeout", 64'd1, 64'd0);
      A = a;
      B = b;
      mult_start = ms;
      div_start = ds;
      e.name = n;
      e.start = cyc + 1;
      if (ms) begin
         p = $signed(a) * $signed(b);
         e.hi = p[63:32];
         e.lo = p[31:0];
         e.dz = 1'b0;
         e.lat = 33;
      end else if (b == '0) begin
         e.hi = mdl_hi;
         e.lo = mdl_lo;
         e.dz = 1'b1;
         e.lat = 1;
      end else begin
         sa64 = {{32{a[31]}}, a};
         sb64 = {{32{b[31]}}, b};
         qq = sa64 / sb64;
         rr = sa64 % sb64;
         e.hi = rr[31:0];
         e.lo = qq[31:0];
         e.dz = 1'b0;
         e.lat = 34;
      end
      if (ms || ds) begin
         sbq.push_back(e);
         mdl_hi = e.hi;
         mdl_lo = e.lo;
      end
      @(negedge clk);
      mult_start = 1'b0;
      div_start = 1'b0;
      A = $urandom;
      B = $urandom;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int t;
      repeat (2) @(negedge clk);
      chk("rst_hi", 64'(Hi), 64'd0);
      chk("rst_lo", 64'(Lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz", 64'(div_zero), 64'd0);
      reset_n = 1'b1;
      issue(32'd7, 32'hFFFFFFFD, 1'b1, 1'b0, "mul_7x-3");
      issue(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, "mul_max");
      issue(32'h80000000, 32'h80000000, 1'b1, 1'b0, "mul_min");
      issue(32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, "div_-7/2");
      issue(32'd100, 32'd7, 1'b0, 1'b1, "div_100/7");
      issue(32'h2AAAAAAB, 32'h66666666, 1'b1, 1'b0, "preload");
      issue(32'd5, 32'd0, 1'b0, 1'b1, "div_zero");
      issue(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, "div_min/-1");
      issue(32'd6, 32'd4, 1'b1, 1'b1, "both_starts");
      repeat (9) @(negedge clk);
      div_start = 1'b1;
      A = 32'd9;
      B = 32'd3;
      @(negedge clk);
      div_start = 1'b0;
      issue($urandom, $urandom, 1'b1, 1'b0, "aborted");
      repeat (10) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_hi", 64'(Hi), 64'd0);
      chk("abort_lo", 64'(Lo), 64'd0);
      sbq.delete();
      mdl_hi = '0;
      mdl_lo = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      issue(32'd3, 32'd5, 1'b1, 1'b0, "mul_3x5");
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
         if ($urandom_range(0, 7) == 0) rb = '0;
         if ($urandom_range(0, 1) == 0) issue(ra, rb, 1'b1, 1'($urandom_range(0, 1)), "rnd_mul");
         else issue(ra, rb, 1'b0, 1'b1, "rnd_div");
      end
      t = 0;
      while (sbq.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (sbq.size() != 0) chk("drain", 64'(sbq.size()), 64'd0);
      repeat (5) @(negedge clk);
      chk("hold_hi", 64'(Hi), 64'(mdl_hi));
      chk("hold_lo", 64'(Lo), 64'(mdl_lo));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
